// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory target sitting on the CPU core's bus. It holds a
// synchronous 16-bit RAM plus a 16-word memory-mapped I/O window (switches,
// LEDs, and an optional 32-bit cycle timer). A host load port fills program
// memory while the core is parked in IDLE.
//
// Parameters:
//   DEPTH_LOG2 - RAM holds 2**DEPTH_LOG2 words; upper address bits alias.
//   MMIO_BASE  - base of the I/O window; address[15:4] == MMIO_BASE[15:4].
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   address   in   core word address
//   data      in   core write data
//   wren      in   core write strobe (one write per edge sampled high)
//   q         out  registered read data, one cycle latency
//   sw        in   board switches (asynchronous, synchronised here)
//   led       out  LED register
//   load_en   in   host load mode (core writes ignored while high)
//   ld_valid  in   host write request
//   ld_addr   in   host write address
//   ld_data   in   host write data
//   ld_ready  out  host write accepted at the next edge (follows load_en)
//
// I/O map (offset = address[3:0]):
//   0 SW (read-only), 1 LED (r/w), 2 TIMER_LO, 3 TIMER_HI, 4-15 read 0.
//
// Build option:
//   MEM_TIMER_EN - when defined, the 32-bit cycle timer and its high-half
//                  latch are built and offsets 2/3 are live. When undefined,
//                  offsets 2/3 read 0 and writes to them are ignored.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_responder #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [15:0] MMIO_BASE  = 16'h8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [15:0] data,
   input  logic        wren,
   output logic [15:0] q,
   input  logic [15:0] sw,
   output logic [15:0] led,
   input  logic        load_en,
   input  logic        ld_valid,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data,
   output logic        ld_ready
);

   localparam int         DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0] OFF_SW  = 4'd0;
   localparam logic [3:0] OFF_LED = 4'd1;
`ifdef MEM_TIMER_EN
   localparam logic [3:0] OFF_TLO = 4'd2;
   localparam logic [3:0] OFF_THI = 4'd3;
`endif

   logic [15:0]           r_ram [DEPTH];
   logic [15:0]           r_q;
   logic [15:0]           r_led;
   logic [15:0]           r_swMeta;
   logic [15:0]           r_swSync;

   logic                  w_coreMmio;
   logic                  w_ldMmio;
   logic                  w_coreWr;
   logic                  w_coreRamWe;
   logic                  w_ldRamWe;
   logic                  w_ramWe;
   logic                  w_ledWe;
   logic [3:0]            w_offset;
   logic [DEPTH_LOG2-1:0] w_rdIdx;
   logic [DEPTH_LOG2-1:0] w_wrIdx;
   logic [15:0]           w_wrData;
   logic [15:0]           w_ramRead;
   logic [15:0]           w_mmioRead;
   logic [15:0]           w_readData;

`ifdef MEM_TIMER_EN
   logic [31:0]           r_timer;
   logic [15:0]           r_timerHi;
   logic                  w_timerClr;
   logic                  w_timerLoRead;
`endif

   // Address decode. Only address[15:4] chooses between the I/O window and
   // RAM; the low DEPTH_LOG2 bits index RAM, so SP-style addresses such as
   // 16'hFFFF fold onto the top RAM words.
   assign w_offset   = address[3:0];
   assign w_coreMmio = (address[15:4] == MMIO_BASE[15:4]);
   assign w_ldMmio   = (ld_addr[15:4] == MMIO_BASE[15:4]);
   assign w_rdIdx    = address[DEPTH_LOG2-1:0];

   // Write arbitration. Load mode owns the RAM write port outright: core
   // writes are dropped and host writes aimed into the I/O window are
   // swallowed (still acknowledged) rather than touching any register.
   assign w_coreWr    = wren & ~load_en;
   assign w_coreRamWe = w_coreWr & ~w_coreMmio;
   assign w_ldRamWe   = load_en & ld_valid & ~w_ldMmio;
   assign w_ramWe     = w_coreRamWe | w_ldRamWe;
   assign w_wrIdx     = load_en ? ld_addr[DEPTH_LOG2-1:0] : w_rdIdx;
   assign w_wrData    = load_en ? ld_data : data;
   assign w_ledWe     = w_coreWr & w_coreMmio & (w_offset == OFF_LED);

   // The host is never back-pressured; acceptance is simply "in load mode".
   assign ld_ready = load_en;

   // RAM array. Deliberately not reset so it maps onto block RAM and keeps
   // its contents across a core reset.
   always_ff @(posedge clk) begin
      if (w_ramWe) begin
         r_ram[w_wrIdx] <= w_wrData;
      end
   end

   // Write-first forwarding: a read of the word being written this edge sees
   // the new data rather than the stale array contents.
   assign w_ramRead = (w_ramWe && (w_wrIdx == w_rdIdx)) ? w_wrData : r_ram[w_rdIdx];

   // Two-flop synchroniser for the asynchronous switch inputs; reads return
   // the second stage only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_swMeta <= '0;
         r_swSync <= '0;
      end else begin
         r_swMeta <= sw;
         r_swSync <= r_swMeta;
      end
   end

   // LED register, written only by the core outside load mode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_led <= '0;
      end else if (w_ledWe) begin
         r_led <= data;
      end
   end

   assign led = r_led;

`ifdef MEM_TIMER_EN
   // Free-running cycle timer. A write to TIMER_LO clears it and wins over
   // the increment, so the value seen the following cycle is 0.
   assign w_timerClr    = w_coreWr & w_coreMmio & (w_offset == OFF_TLO);
   assign w_timerLoRead = w_coreMmio & (w_offset == OFF_TLO);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
      end else if (w_timerClr) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 32'd1;
      end
   end

   // Reading TIMER_LO snapshots the high half at the same edge so a later
   // TIMER_HI read pairs with that low half even if a carry occurs between.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timerHi <= '0;
      end else if (w_timerLoRead) begin
         r_timerHi <= r_timer[31:16];
      end
   end
`endif

   // I/O window read mux. Unused offsets (and the timer offsets when the
   // timer is not built) fall through to the default of 0.
   always_comb begin
      w_mmioRead = '0;
      case (w_offset)
         OFF_SW:  w_mmioRead = r_swSync;
         OFF_LED: w_mmioRead = r_led;
`ifdef MEM_TIMER_EN
         OFF_TLO: w_mmioRead = r_timer[15:0];
         OFF_THI: w_mmioRead = r_timerHi;
`endif
         default: w_mmioRead = '0;
      endcase
   end

   assign w_readData = w_coreMmio ? w_mmioRead : w_ramRead;

   // Registered read port: every edge captures the value for the address
   // presented in the preceding cycle, giving a one-per-cycle pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= w_readData;
      end
   end

   assign q = r_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Word-addressed memory target for the CPU core's bus. It receives the core's address, write data and write enable, and returns read data on q. It contains a synchronous RAM and a small memory-mapped I/O window (switches, LEDs, cycle timer). It also has a host load port, used to fill program memory while the core is held idle.

Parameters:
DEPTH_LOG2, 12, RAM holds 2^DEPTH_LOG2 16-bit words; RAM index = address[DEPTH_LOG2-1:0], so upper address bits alias.
MMIO_BASE, 16'h8000, base of the 16-word I/O window; address[15:4] == MMIO_BASE[15:4] selects I/O, otherwise RAM.

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
address  in  16  core word address, registered by core
data  in  16  core write data
wren  in  1  core write strobe; one write per rising edge sampled high
q  out  16  read data, registered
sw  in  16  board switches, asynchronous
led  out  16  LED register output
load_en  in  1  host load mode; system asserts only while core sits in IDLE
ld_valid  in  1  host write request
ld_addr  in  16  host write address
ld_data  in  16  host write data
ld_ready  out  1  host write accepted at next edge when ld_valid=1

Behaviour:
- Reset values: q=0, led=0, timer=0, timer_hi_latch=0, sw sync flops=0. RAM contents are not cleared. ld_ready follows load_en combinationally.
- Read: every rising edge, q <= read value of the current address. Latency is 1 cycle.
  - Address presented after edge E0 gives q valid from E1, sampled by the core at E2.
  - Back-to-back addresses pipeline at one per cycle (the core's FETCH1/FETCH2 pattern).
- Read-during-write to the same RAM word at the same edge: q returns the new data (write-first).
- Core write: at an edge with wren=1 and load_en=0, store data to the decoded target.
  - Consecutive cycles with wren=1 at different addresses (call sequence) each commit once.
- Stack aliasing: SP-style addresses 16'hFFFF, 16'hFFFE map to RAM[2^DEPTH_LOG2-1], RAM[2^DEPTH_LOG2-2].
- Load mode (load_en=1):
  - Core writes are ignored.
  - Each edge with ld_valid=1 writes ld_data to RAM[ld_addr[DEPTH_LOG2-1:0]].
  - ld_addr inside the MMIO window is dropped and still consumed (ld_ready=1).
  - Core reads continue to be served.
- MMIO map (offset = address[3:0]):
  - 0: SW, read-only. sw passes through a 2-flop synchronizer; a read returns the second flop. Writes ignored.
  - 1: LED, read/write. Write updates led at the edge; a read returns the current led.
  - 2: TIMER_LO. A read returns timer[15:0] and, at the same edge, latches timer[31:16] into timer_hi_latch. Any write clears the timer to 0 (write data ignored).
  - 3: TIMER_HI. A read returns timer_hi_latch.
  - 4-15: read 0, writes ignored.
- Timer: 32-bit, increments every cycle, wraps 32'hFFFFFFFF -> 0.
  - A clear write has priority over the increment; the value is 0 on the following cycle.
- Reset mid-operation: asynchronous; q, led and timer return to 0 immediately. A write on the same edge as reset deassertion is not guaranteed.
- Width rules: all data 16-bit, no sign handling. Unmatched MMIO offsets and upper-address aliasing are not errors.

Optional Feature:
MEM_TIMER_EN:
- Defined: timer and offsets 2/3 behave as above.
- Undefined: no timer or latch logic; offsets 2 and 3 read 0 and writes are ignored. All other behaviour is unchanged.

Test Plan:
1. Load mode: load_en=1; write 0x0000<-16'h0100, 0x0001<-16'h0005 via ld_valid. Then load_en=0; present address 0 then 1 on consecutive cycles -> q=16'h0100 one edge after address 0, q=16'h0005 the next edge.
2. Core write/read: wren=1, address=16'h0010, data=16'hBEEF for one cycle; later read 16'h0010 -> q=16'hBEEF. Read-during-write to 16'h0011 with data 16'h1234 -> q=16'h1234 at that edge.
3. Stack aliasing: write 16'hAAAA to 16'hFFFF, then 16'h5555 to 16'hFFFE on back-to-back cycles. Read 16'h0FFF -> 16'hAAAA; read 16'h0FFE -> 16'h5555 (DEPTH_LOG2=12).
4. MMIO: sw=16'h00F3 held for 3 cycles, read 16'h8000 -> 16'h00F3. Write 16'h8001<-16'h0A5A -> led=16'h0A5A; read back 16'h0A5A. Read 16'h8004 -> 0. Core write in load mode to 16'h8001 -> led unchanged.
5. Timer (MEM_TIMER_EN defined): write 16'h8002 -> timer cleared. Read 16'h8002 exactly 100 cycles after the clear edge -> q=100 (16'h0064). Force timer near 32'h0000FFFF, read LO then HI -> HI returns the value latched at the LO read, not a later carry.
6. Reset mid-run: assert reset with led=16'h0A5A and q nonzero -> led=0, q=0 immediately. RAM word 16'h0010 still reads 16'hBEEF after release.
